// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of a 5-stage MIPS pipeline.
//
// Takes the EX/MEM register outputs, resolves branches combinationally,
// runs loads/stores against a single-port data memory through a
// req/ready handshake, stalls the upstream pipeline while an access is
// outstanding, and registers the MEM/WB bundle for write-back.
//
// Handshake: the stage holds mem_req high with stable mem_we/mem_addr/
// mem_wdata from the first WAIT cycle until the cycle in which mem_ready=1
// (inclusive) or the timeout cycle. mem_rdata is sampled only in a cycle
// where mem_req=1 and mem_ready=1. mem_ready seen while mem_req=0 is ignored.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   controlBits[4:0]     {RegWrite, MemtoReg, Branch, MemRead, MemWrite}
//   addResultado         branch target
//   resultadoULA         ALU result / memory address
//   saidaRead            store data
//   saidaMux5b           destination register
//   zero                 ALU zero flag
//   pc_src, pc_target    branch decision and target (combinational)
//   stall                freeze upstream stages this cycle (combinational)
//   mem_req, mem_we,
//   mem_addr, mem_wdata  data-memory request side
//   mem_rdata, mem_ready data-memory response side
//   wb_ctrl, wb_rdata,
//   wb_alu, wb_rd        registered MEM/WB bundle
//   err                  sticky access-timeout flag
//   state_dbg            current FSM state (0 = IDLE, 1 = WAIT)

module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  controlBits,
    input  logic [31:0] addResultado,
    input  logic [31:0] resultadoULA,
    input  logic [31:0] saidaRead,
    input  logic [4:0]  saidaMux5b,
    input  logic        zero,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  wb_ctrl,
    output logic [31:0] wb_rdata,
    output logic [31:0] wb_alu,
    output logic [4:0]  wb_rd,
    output logic        err,
    output logic [0:0]  state_dbg
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          memop;
    logic          is_write;
    logic          timed_out;

    assign memop     = controlBits[1] | controlBits[0];
    // MemWrite wins when both MemRead and MemWrite are set.
    assign is_write  = controlBits[0];
    assign timed_out = (state == S_WAIT) && !mem_ready && (cnt == CW'(TIMEOUT - 1));

    assign pc_src    = controlBits[2] & zero;
    assign pc_target = addResultado;

    assign mem_we    = is_write;
    assign mem_addr  = resultadoULA;
    assign mem_wdata = saidaRead;
    assign state_dbg = state;

    always_comb begin
        mem_req = 1'b0;
        stall   = 1'b0;
        if (state == S_IDLE) begin
            // The request is issued one cycle after arrival, so IDLE only stalls.
            stall = memop;
        end else begin
            mem_req = 1'b1;
            // Release upstream on completion, and also on the timeout cycle so
            // the dropped instruction does not wedge the pipeline.
            stall = !mem_ready && !timed_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            err      <= 1'b0;
            wb_ctrl  <= 2'b00;
            wb_rdata <= 32'h0;
            wb_alu   <= 32'h0;
            wb_rd    <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (memop) begin
                        state   <= S_WAIT;
                        cnt     <= '0;
                        wb_ctrl <= 2'b00;
                    end else begin
                        wb_ctrl <= controlBits[4:3];
                        wb_alu  <= resultadoULA;
                        wb_rd   <= saidaMux5b;
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        state   <= S_IDLE;
                        wb_ctrl <= controlBits[4:3];
                        wb_alu  <= resultadoULA;
                        wb_rd   <= saidaMux5b;
                        if (!is_write) begin
                            wb_rdata <= mem_rdata;
                        end
                    end else if (timed_out) begin
                        // Abandon the access: the instruction becomes a bubble.
                        state   <= S_IDLE;
                        err     <= 1'b1;
                        wb_ctrl <= 2'b00;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        wb_ctrl <= 2'b00;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed testbench for mem_stage (TIMEOUT=4).
// Inputs change 1 ns after the rising edge; outputs are read 1 ns later,
// mid-cycle, well away from the active edge.

module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic [4:0]  controlBits;
    logic [31:0] addResultado;
    logic [31:0] resultadoULA;
    logic [31:0] saidaRead;
    logic [4:0]  saidaMux5b;
    logic        zero;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  wb_ctrl;
    logic [31:0] wb_rdata;
    logic [31:0] wb_alu;
    logic [4:0]  wb_rd;
    logic        err;
    logic [0:0]  state_dbg;

    int total;
    int bad;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .controlBits  (controlBits),
        .addResultado (addResultado),
        .resultadoULA (resultadoULA),
        .saidaRead    (saidaRead),
        .saidaMux5b   (saidaMux5b),
        .zero         (zero),
        .pc_src       (pc_src),
        .pc_target    (pc_target),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .wb_ctrl      (wb_ctrl),
        .wb_rdata     (wb_rdata),
        .wb_alu       (wb_alu),
        .wb_rd        (wb_rd),
        .err          (err),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] cb, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] rd);
        controlBits  = cb;
        resultadoULA = alu;
        saidaRead    = sd;
        saidaMux5b   = rd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        set_in(5'b00000, 32'h0, 32'h0, 5'd0);
        addResultado = 32'h0; zero = 1'b0; mem_rdata = 32'h0; mem_ready = 1'b0;
        step();
        step();
        total++; if (wb_ctrl !== 2'b00) begin bad++; $display("FAIL reset_wb_ctrl got=%b exp=00", wb_ctrl); end
        total++; if (wb_alu !== 32'h0) begin bad++; $display("FAIL reset_wb_alu got=%h exp=0", wb_alu); end
        total++; if (wb_rd !== 5'd0) begin bad++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
        total++; if (wb_rdata !== 32'h0) begin bad++; $display("FAIL reset_wb_rdata got=%h exp=0", wb_rdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_req_stall got=%b%b exp=00", mem_req, stall); end
        // IDLE rule still applies under reset: stall follows memop
        controlBits = 5'b11010;
        #1;
        total++; if (stall !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL reset_memop_stall got stall=%b req=%b exp 1/0", stall, mem_req); end
        controlBits = 5'b00000;
        step();
        reset = 1'b1;
    endtask

    task automatic test_alu();
        set_in(5'b10000, 32'h0000_002A, 32'h0, 5'd8);
        mem_ready = 1'b1;            // ignored outside WAIT
        mem_rdata = 32'h5555_5555;
        #1;
        total++; if (stall !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL alu_comb got stall=%b req=%b exp 0/0", stall, mem_req); end
        step();
        mem_ready = 1'b0;
        total++; if (wb_ctrl !== 2'b10) begin bad++; $display("FAIL alu_wb_ctrl got=%b exp=10", wb_ctrl); end
        total++; if (wb_alu !== 32'h2A) begin bad++; $display("FAIL alu_wb_alu got=%h exp=2a", wb_alu); end
        total++; if (wb_rd !== 5'd8) begin bad++; $display("FAIL alu_wb_rd got=%0d exp=8", wb_rd); end
        total++; if (wb_rdata !== 32'h0 || state_dbg !== 1'b0) begin bad++; $display("FAIL alu_hold got rdata=%h state=%b exp 0/0", wb_rdata, state_dbg); end
    endtask

    task automatic test_load();
        set_in(5'b11010, 32'h0000_0100, 32'h0, 5'd5);
        #1;
        total++; if (stall !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL load_c0 got stall=%b req=%b exp 1/0", stall, mem_req); end
        step();
        total++; if (stall !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            bad++; $display("FAIL load_c1 got stall=%b req=%b we=%b addr=%h exp 1/1/0/100", stall, mem_req, mem_we, mem_addr); end
        total++; if (wb_ctrl !== 2'b00 || wb_alu !== 32'h2A) begin bad++; $display("FAIL load_bubble got ctrl=%b alu=%h exp 00/2a", wb_ctrl, wb_alu); end
        step();
        total++; if (stall !== 1'b1 || mem_req !== 1'b1) begin bad++; $display("FAIL load_c2 got stall=%b req=%b exp 1/1", stall, mem_req); end
        step();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (stall !== 1'b0 || mem_req !== 1'b1) begin bad++; $display("FAIL load_c3 got stall=%b req=%b exp 0/1", stall, mem_req); end
        step();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        set_in(5'b00000, 32'h0, 32'h0, 5'd0);
        #1;
        total++; if (wb_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_wb_rdata got=%h exp=deadbeef", wb_rdata); end
        total++; if (wb_ctrl !== 2'b11 || wb_alu !== 32'h100 || wb_rd !== 5'd5) begin
            bad++; $display("FAIL load_wb got ctrl=%b alu=%h rd=%0d exp 11/100/5", wb_ctrl, wb_alu, wb_rd); end
        total++; if (mem_req !== 1'b0 || stall !== 1'b0 || state_dbg !== 1'b0) begin
            bad++; $display("FAIL load_after got req=%b stall=%b state=%b exp 0/0/0", mem_req, stall, state_dbg); end
    endtask

    task automatic test_store(input logic [4:0] cb);
        set_in(cb, 32'h0000_0040, 32'h0000_1234, 5'd3);
        #1;
        total++; if (stall !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL store_c0 cb=%b got stall=%b req=%b exp 1/0", cb, stall, mem_req); end
        step();
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234 || mem_addr !== 32'h40) begin
            bad++; $display("FAIL store_req cb=%b got req=%b we=%b wdata=%h addr=%h exp 1/1/1234/40", cb, mem_req, mem_we, mem_wdata, mem_addr); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL store_stall cb=%b got=%b exp=0", cb, stall); end
        step();
        mem_ready = 1'b0;
        set_in(5'b00000, 32'h0, 32'h0, 5'd0);
        #1;
        total++; if (wb_ctrl !== 2'b00 || wb_rdata !== 32'hDEAD_BEEF || wb_alu !== 32'h40) begin
            bad++; $display("FAIL store_wb cb=%b got ctrl=%b rdata=%h alu=%h exp 00/deadbeef/40", cb, wb_ctrl, wb_rdata, wb_alu); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL store_after cb=%b got req=%b exp 0", cb, mem_req); end
    endtask

    task automatic test_branch();
        set_in(5'b00100, 32'h0, 32'h0, 5'd0);
        addResultado = 32'h0000_0080; zero = 1'b1;
        #1;
        total++; if (pc_src !== 1'b1 || pc_target !== 32'h80) begin bad++; $display("FAIL branch_taken got src=%b tgt=%h exp 1/80", pc_src, pc_target); end
        zero = 1'b0;
        #1;
        total++; if (pc_src !== 1'b0) begin bad++; $display("FAIL branch_not_taken got=%b exp=0", pc_src); end
        controlBits = 5'b10000; zero = 1'b1;
        #1;
        total++; if (pc_src !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL branch_nobranch got src=%b stall=%b exp 0/0", pc_src, stall); end
        zero = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        set_in(5'b11010, 32'h0000_0200, 32'h0, 5'd4);
        step();
        mem_ready = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        step();
        mem_rdata = 32'h5A5A_5A5A;   // mem_ready still 1 but FSM is IDLE now
        set_in(5'b11010, 32'h0000_0204, 32'h0, 5'd6);
        #1;
        total++; if (state_dbg !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b1) begin
            bad++; $display("FAIL b2b_gap got state=%b req=%b stall=%b exp 0/0/1", state_dbg, mem_req, stall); end
        total++; if (wb_rdata !== 32'hA5A5_A5A5 || wb_rd !== 5'd4) begin bad++; $display("FAIL b2b_first got rdata=%h rd=%0d exp a5a5a5a5/4", wb_rdata, wb_rd); end
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h204 || stall !== 1'b0) begin
            bad++; $display("FAIL b2b_second_req got req=%b addr=%h stall=%b exp 1/204/0", mem_req, mem_addr, stall); end
        step();
        mem_ready = 1'b0;
        set_in(5'b00000, 32'h0, 32'h0, 5'd0);
        #1;
        total++; if (wb_rdata !== 32'h5A5A_5A5A || wb_rd !== 5'd6) begin bad++; $display("FAIL b2b_second got rdata=%h rd=%0d exp 5a5a5a5a/6", wb_rdata, wb_rd); end
    endtask

    task automatic test_timeout();
        set_in(5'b11010, 32'h0000_0300, 32'h0, 5'd7);
        step();
        for (int i = 1; i <= 4; i++) begin
            total++; if (mem_req !== 1'b1 || stall !== (i < 4)) begin
                bad++; $display("FAIL timeout_wait%0d got req=%b stall=%b exp 1/%0d", i, mem_req, stall, (i < 4)); end
            step();
        end
        set_in(5'b10000, 32'h0000_0077, 32'h0, 5'd9);
        #1;
        total++; if (err !== 1'b1 || wb_ctrl !== 2'b00 || state_dbg !== 1'b0) begin
            bad++; $display("FAIL timeout_end got err=%b ctrl=%b state=%b exp 1/00/0", err, wb_ctrl, state_dbg); end
        total++; if (mem_req !== 1'b0 || stall !== 1'b0 || wb_rd !== 5'd6) begin
            bad++; $display("FAIL timeout_idle got req=%b stall=%b rd=%0d exp 0/0/6", mem_req, stall, wb_rd); end
        step();
        total++; if (wb_ctrl !== 2'b10 || wb_alu !== 32'h77 || wb_rd !== 5'd9 || err !== 1'b1) begin
            bad++; $display("FAIL timeout_next got ctrl=%b alu=%h rd=%0d err=%b exp 10/77/9/1", wb_ctrl, wb_alu, wb_rd, err); end
    endtask

    task automatic test_async_reset();
        set_in(5'b11010, 32'h0000_0400, 32'h0, 5'd10);
        step();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL areset_pre got req=%b exp 1", mem_req); end
        #1 reset = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || err !== 1'b0 || state_dbg !== 1'b0 || stall !== 1'b1) begin
            bad++; $display("FAIL areset_now got req=%b err=%b state=%b stall=%b exp 0/0/0/1", mem_req, err, state_dbg, stall); end
        total++; if (wb_ctrl !== 2'b00 || wb_rdata !== 32'h0 || wb_alu !== 32'h0 || wb_rd !== 5'd0) begin
            bad++; $display("FAIL areset_wb got ctrl=%b rdata=%h alu=%h rd=%0d exp all 0", wb_ctrl, wb_rdata, wb_alu, wb_rd); end
        #4 reset = 1'b1;
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin bad++; $display("FAIL areset_restart got req=%b addr=%h exp 1/400", mem_req, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_ready = 1'b0;
        set_in(5'b00000, 32'h0, 32'h0, 5'd0);
        #1;
        total++; if (wb_rdata !== 32'h1111_2222 || wb_ctrl !== 2'b11 || wb_rd !== 5'd10) begin
            bad++; $display("FAIL areset_done got rdata=%h ctrl=%b rd=%0d exp 11112222/11/10", wb_rdata, wb_ctrl, wb_rd); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alu();
        test_load();
        test_store(5'b00001);
        test_store(5'b00011);
        test_branch();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
